// File: rtl/game_over_sequencer.sv
// Game-over banner sequencer: slides the banner in one step per frame, holds it,
// blinks it while waiting for fire, then emits a single-cycle restart pulse.
module game_over_sequencer #(
  parameter int unsigned CORDW        = 10,
  parameter int unsigned H_RES        = 640,
  parameter int unsigned TARGET_X     = 256,
  parameter int unsigned STEP         = 8,
  parameter int unsigned HOLD_FRAMES  = 60,
  parameter int unsigned BLINK_FRAMES = 16,
  parameter int unsigned TICK_LINE    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CORDW-1:0] pixel,
  input  logic [CORDW-1:0] line,
  input  logic             game_over,
  input  logic             fire,
  output logic [9:0]       game_over_x,
  output logic             banner_en,
  output logic             restart,
  output logic             busy
);

  localparam int unsigned XW  = 10;
  localparam int unsigned XW1 = XW + 1;
  localparam int unsigned CW  = 8;

  localparam logic [XW-1:0]  X_PARK    = XW'(H_RES);
  localparam logic [XW-1:0]  X_TARGET  = XW'(TARGET_X);
  localparam logic [XW-1:0]  X_STEP    = XW'(STEP);
  // One bit wider so TARGET_X + STEP cannot wrap in the compare
  localparam logic [XW1-1:0] SLIDE_MIN = XW1'(TARGET_X + STEP);
  localparam logic [CW-1:0]  HOLD_LIM  = CW'(HOLD_FRAMES);
  localparam logic [CW-1:0]  BLINK_LIM = CW'(BLINK_FRAMES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SLIDE,
    S_HOLD,
    S_WAIT,
    S_RESTART
  } state_t;

  state_t        state;
  logic          tick_cond_q, tick_cond_d;
  logic          go_q, go_d, fire_q, fire_d;
  logic [CW-1:0] frame_cnt, blink_cnt;

  logic          tick_cond_c, tick, go_rise, fire_rise;
  logic [CW-1:0] frame_nxt, blink_nxt;

  // Single-cycle event strobes and saturating counter increments
  always_comb begin
    tick_cond_c = (line == CORDW'(TICK_LINE)) && (pixel == '0);
    tick        = tick_cond_q & ~tick_cond_d;
    go_rise     = go_q & ~go_d;
    fire_rise   = fire_q & ~fire_d;
    frame_nxt   = (frame_cnt == '1) ? frame_cnt : frame_cnt + CW'(1);
    blink_nxt   = (blink_cnt == '1) ? blink_cnt : blink_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      tick_cond_q <= 1'b0;
      tick_cond_d <= 1'b0;
      go_q        <= 1'b0;
      go_d        <= 1'b0;
      fire_q      <= 1'b0;
      fire_d      <= 1'b0;
      frame_cnt   <= '0;
      blink_cnt   <= '0;
      game_over_x <= X_PARK;
      banner_en   <= 1'b0;
      restart     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      tick_cond_q <= tick_cond_c;
      tick_cond_d <= tick_cond_q;
      go_q        <= game_over;
      go_d        <= go_q;
      fire_q      <= fire;
      fire_d      <= fire_q;
      restart     <= 1'b0;

      case (state)
        S_IDLE: begin
          if (go_rise) begin
            state     <= S_SLIDE;
            banner_en <= 1'b1;
            busy      <= 1'b1;
          end
        end

        // Compare before subtracting so x clamps at TARGET_X and never underflows
        S_SLIDE: begin
          if (tick) begin
            if ({1'b0, game_over_x} >= SLIDE_MIN) begin
              game_over_x <= game_over_x - X_STEP;
            end else begin
              game_over_x <= X_TARGET;
              frame_cnt   <= '0;
              state       <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          if (tick) begin
            if (frame_nxt >= HOLD_LIM) begin
              frame_cnt <= '0;
              blink_cnt <= '0;
              state     <= S_WAIT;
            end else begin
              frame_cnt <= frame_nxt;
            end
          end
        end

        // Fire takes priority over a coincident blink toggle
        S_WAIT: begin
          if (fire_rise) begin
            state       <= S_RESTART;
            restart     <= 1'b1;
            banner_en   <= 1'b0;
            game_over_x <= X_PARK;
          end else if (tick) begin
            if (blink_nxt >= BLINK_LIM) begin
              banner_en <= ~banner_en;
              blink_cnt <= '0;
            end else begin
              blink_cnt <= blink_nxt;
            end
          end
        end

        S_RESTART: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state       <= S_IDLE;
          game_over_x <= X_PARK;
          banner_en   <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_over_sequencer.sv
// Randomised bench for game_over_sequencer: two instances (STEP 8 and 7) checked
// every cycle against a closed-form frame-level model of the banner sequence.
module tb_game_over_sequencer;

  localparam int H_RES   = 640;
  localparam int TGT_X   = 256;
  localparam int HOLD_F  = 60;
  localparam int BLINK_F = 16;
  localparam int PW      = 6;
  localparam int LH      = 4;
  localparam int FR      = PW * LH;

  localparam int M_IDLE = 0, M_SLIDE = 1, M_HOLD = 2, M_WAIT = 3, M_RST = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] pixel = '0;
  logic [9:0] line = '0;
  logic       game_over = 1'b0;
  logic       fire = 1'b0;

  logic [9:0] x0, x1;
  logic       ben0, ben1, rs0, rs1, busy0, busy1;

  always #5 clk = ~clk;

  game_over_sequencer u_dut0 (
    .clk(clk), .rst_n(rst_n), .pixel(pixel), .line(line),
    .game_over(game_over), .fire(fire),
    .game_over_x(x0), .banner_en(ben0), .restart(rs0), .busy(busy0)
  );

  game_over_sequencer #(.STEP(7)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .pixel(pixel), .line(line),
    .game_over(game_over), .fire(fire),
    .game_over_x(x1), .banner_en(ben1), .restart(rs1), .busy(busy1)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame-level model: per instance, mode plus ticks elapsed in that mode
  int m_mode[2], m_x[2], m_ben[2], m_rst[2], m_cnt[2];
  int step_p[2] = '{8, 7};
  bit prev_tc, prev_go, prev_fire;
  bit pend_tick, pend_go, pend_fire;
  int rc0, rc1, min_x1;

  task automatic model_apply(input int i);
    int slide_ticks;
    // Tick on which the clamp to TARGET_X and the move to HOLD happen
    slide_ticks = (H_RES - TGT_X) / step_p[i] + 1;
    m_rst[i] = 0;
    case (m_mode[i])
      M_IDLE: if (pend_go) begin m_mode[i] = M_SLIDE; m_ben[i] = 1; m_cnt[i] = 0; end
      M_SLIDE: if (pend_tick) begin
        m_cnt[i]++;
        if (m_cnt[i] >= slide_ticks) begin
          m_x[i] = TGT_X; m_mode[i] = M_HOLD; m_cnt[i] = 0;
        end else begin
          m_x[i] = H_RES - step_p[i] * m_cnt[i];
        end
      end
      M_HOLD: if (pend_tick) begin
        m_cnt[i]++;
        if (m_cnt[i] >= HOLD_F) begin m_mode[i] = M_WAIT; m_cnt[i] = 0; end
      end
      M_WAIT: begin
        if (pend_fire) begin
          m_mode[i] = M_RST; m_ben[i] = 0; m_rst[i] = 1; m_x[i] = H_RES;
        end else if (pend_tick) begin
          m_cnt[i]++;
          m_ben[i] = ((m_cnt[i] / BLINK_F) % 2 == 0) ? 1 : 0;
        end
      end
      default: m_mode[i] = M_IDLE;
    endcase
  endtask

  task automatic model_edge();
    bit tc_now;
    tc_now = (line == 0) && (pixel == 0);
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_mode[i] = M_IDLE; m_x[i] = H_RES; m_ben[i] = 0; m_rst[i] = 0; m_cnt[i] = 0;
      end
      prev_tc = 0; prev_go = 0; prev_fire = 0;
      pend_tick = 0; pend_go = 0; pend_fire = 0;
      return;
    end
    for (int i = 0; i < 2; i++) model_apply(i);
    // Input edges seen now take effect at the following clock edge
    pend_tick = tc_now & ~prev_tc;
    pend_go   = game_over & ~prev_go;
    pend_fire = fire & ~prev_fire;
    prev_tc = tc_now; prev_go = game_over; prev_fire = fire;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("x0", int'(x0), m_x[0]);
    chk("ben0", int'(ben0), m_ben[0]);
    chk("restart0", int'(rs0), m_rst[0]);
    chk("busy0", int'(busy0), (m_mode[0] != M_IDLE) ? 1 : 0);
    chk("x1", int'(x1), m_x[1]);
    chk("ben1", int'(ben1), m_ben[1]);
    chk("restart1", int'(rs1), m_rst[1]);
    chk("busy1", int'(busy1), (m_mode[1] != M_IDLE) ? 1 : 0);
    if (rs0) rc0++;
    if (rs1) rc1++;
    if (busy1 && int'(x1) < min_x1) min_x1 = int'(x1);
    if (pixel == 10'(PW - 1)) begin
      pixel = '0;
      line  = (line == 10'(LH - 1)) ? '0 : line + 10'd1;
    end else begin
      pixel = pixel + 10'd1;
    end
  endtask

  task automatic frames(input int n);
    repeat (n * FR) step();
  endtask

  initial begin
    int b;
    rst_n = 1'b0;
    repeat (5) step();
    chk("reset_x", int'(x0), 640);
    chk("reset_ben", int'(ben0), 0);
    chk("reset_restart", int'(rs0), 0);
    chk("reset_busy", int'(busy0), 0);
    rst_n = 1'b1;
    repeat ($urandom_range(3, 30)) step();

    // Full sequences: slide, hold with fire held, blink, second game_over, fire
    for (int it = 0; it < 2; it++) begin
      rc0 = 0; rc1 = 0; min_x1 = 1023;
      game_over = 1'b1;
      repeat ($urandom_range(1, 100)) step();
      game_over = 1'b0;
      frames(70);
      fire = 1'b1;
      frames(50);
      fire = 1'b0;
      chk("no_restart_held0", rc0, 0);
      chk("no_restart_held1", rc1, 0);
      chk("min_x1", min_x1, TGT_X);
      frames($urandom_range(1, 20));
      game_over = 1'b1;
      repeat ($urandom_range(1, 50)) step();
      game_over = 1'b0;
      frames($urandom_range(1, 20));
      repeat ($urandom_range(0, FR - 1)) step();
      fire = 1'b1;
      repeat ($urandom_range(4, 40)) step();
      fire = 1'b0;
      repeat (4) step();
      chk("restart_pulses0", rc0, 1);
      chk("restart_pulses1", rc1, 1);
      chk("park_x0", int'(x0), 640);
      chk("idle_busy0", int'(busy0), 0);
      repeat ($urandom_range(5, 40)) step();
    end

    // Reset while sliding, then a fresh slide from the park position
    rc0 = 0; rc1 = 0;
    game_over = 1'b1;
    repeat ($urandom_range(1, 10)) step();
    game_over = 1'b0;
    b = 0;
    while (x0 != 10'd400 && b < 2000) begin step(); b++; end
    chk("reach_400", int'(x0), 400);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midreset_x", int'(x0), 640);
    chk("midreset_busy", int'(busy0), 0);
    repeat ($urandom_range(5, 60)) step();
    chk("midreset_no_restart", rc0 + rc1, 0);
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    frames(20);
    chk("reslide_busy0", int'(busy0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
